board_io_ctrl: RTL and testbench

//  Board-level I/O controller between the FPGA top and the Wally_CS SoC GPIO.
//  - Synchronises and debounces W_KEY push-buttons and W_SW slide switches.
//  - Raises per-key press/release pulses and sticky pending flags.
//  - Drives N_HEX seven-segment displays from a written 4-bit-per-digit value with a blank mask.
//  - Replaces direct raw-pin GPIO wiring and the static HEX tie-off.

---
 rtl/board_io_pkg.sv | 38 +++
 rtl/board_io_debounce.sv | 61 ++++++
 rtl/board_io_ctrl.sv | 110 +++++++++++
 tb/tb_board_io_ctrl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared constants and helpers for the board I/O controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package board_io_pkg;

  // All segments off; segments are active-low.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Hex nibble to active-low segment pattern, bit0 = a .. bit6 = g.
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  // Width of a counter that must hold values 0..ticks.
  function automatic int cnt_width(input int ticks);
    return $clog2(ticks + 1);
  endfunction

endpackage

// File: rtl/board_io_debounce.sv
// Single-channel 2-FF synchroniser plus tick-based debouncer.
// Latency: 2 cycles + (DEBOUNCE_TICKS-1 .. DEBOUNCE_TICKS) tick periods.
// Backpressure: none; din is sampled every cycle.
module board_io_debounce
  import board_io_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic din,
  output logic dout
);

  localparam int CW = cnt_width(DEBOUNCE_TICKS);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_TICKS);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_inc;

  // Next-state: count ticks while the synced input disagrees; any agreement restarts the count.
  always_comb begin
    sync1_d  = din;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_inc  = cnt_q + CW'(1);
    cnt_d    = cnt_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (tick) begin
      if (cnt_inc == CNT_DONE) begin
        stable_d = sync2_q;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O: debounced keys/switches, key press/release events with sticky pending, 7-seg HEX drive.
// Latency: debounce per board_io_debounce; events +1 cycle after stable change; HEX 1 cycle after hex_we_i.
// Backpressure: none; all inputs sampled every cycle, key_clr_i is write-1-to-clear.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int W_KEY          = 4,
  parameter int W_SW           = 18,
  parameter int N_HEX          = 8,
  parameter int TICK_CYCLES    = 50000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter bit KEY_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W_KEY-1:0]     key_i,
  input  logic [W_SW-1:0]      sw_i,
  output logic [W_KEY-1:0]     key_o,
  output logic [W_SW-1:0]      sw_o,
  output logic [W_KEY-1:0]     key_press_o,
  output logic [W_KEY-1:0]     key_release_o,
  output logic [W_KEY-1:0]     key_pending_o,
  input  logic [W_KEY-1:0]     key_clr_i,
  input  logic                 hex_we_i,
  input  logic [4*N_HEX-1:0]   hex_value_i,
  input  logic [N_HEX-1:0]     hex_blank_i,
  output logic [7*N_HEX-1:0]   hex_o
);

  localparam int NCH = W_KEY + W_SW;
  localparam int PW  = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  logic [PW-1:0]      presc_q, presc_d;
  logic               tick;
  logic [NCH-1:0]     raw_in;
  logic [NCH-1:0]     deb_out;
  logic [W_KEY-1:0]   key_dly_q, key_dly_d;
  logic [W_KEY-1:0]   press_q, press_d;
  logic [W_KEY-1:0]   release_q, release_d;
  logic [W_KEY-1:0]   pending_q, pending_d;
  logic [7*N_HEX-1:0] hex_q, hex_d;

  // Shared tick prescaler: one-cycle tick when the count wraps.
  always_comb begin
    tick    = (presc_q == PRESC_LAST);
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Keys are normalised to 1 = pressed before synchronisation.
  assign raw_in = {sw_i, key_i ^ {W_KEY{KEY_ACTIVE_LOW}}};

  for (genvar i = 0; i < NCH; i++) begin : g_deb
    board_io_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .tick (tick),
      .din  (raw_in[i]),
      .dout (deb_out[i])
    );
  end

  assign key_o = deb_out[W_KEY-1:0];
  assign sw_o  = deb_out[NCH-1:W_KEY];

  // Edge detect on debounced keys; a press pulse outranks a same-cycle clear.
  always_comb begin
    key_dly_d = key_o;
    press_d   = key_o & ~key_dly_q;
    release_d = ~key_o & key_dly_q;
    pending_d = (pending_q & ~key_clr_i) | press_q;
  end

  // Digit registers reload on every write, blank mask taking precedence over the nibble.
  always_comb begin
    hex_d = hex_q;
    if (hex_we_i) begin
      for (int d = 0; d < N_HEX; d++) begin
        hex_d[7*d +: 7] = hex_blank_i[d] ? SEG_BLANK : seg7(hex_value_i[4*d +: 4]);
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q   <= '0;
      key_dly_q <= '0;
      press_q   <= '0;
      release_q <= '0;
      pending_q <= '0;
      hex_q     <= {N_HEX{SEG_BLANK}};
    end else begin
      presc_q   <= presc_d;
      key_dly_q <= key_dly_d;
      press_q   <= press_d;
      release_q <= release_d;
      pending_q <= pending_d;
      hex_q     <= hex_d;
    end
  end

  assign key_press_o   = press_q;
  assign key_release_o = release_q;
  assign key_pending_o = pending_q;
  assign hex_o         = hex_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl with a behavioural reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_board_io_ctrl;

  localparam int W_KEY = 4;
  localparam int W_SW  = 18;
  localparam int N_HEX = 8;
  localparam int TC    = 4;
  localparam int DT    = 3;
  localparam int NCH   = W_KEY + W_SW;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [W_KEY-1:0]     key_i = '1;
  logic [W_SW-1:0]      sw_i = '0;
  logic [W_KEY-1:0]     key_o, key_press_o, key_release_o, key_pending_o;
  logic [W_SW-1:0]      sw_o;
  logic [W_KEY-1:0]     key_clr_i = '0;
  logic                 hex_we_i = 1'b0;
  logic [4*N_HEX-1:0]   hex_value_i = '0;
  logic [N_HEX-1:0]     hex_blank_i = '0;
  logic [7*N_HEX-1:0]   hex_o;

  int n_chk = 0;
  int n_pass = 0;

  board_io_ctrl #(
    .W_KEY(W_KEY), .W_SW(W_SW), .N_HEX(N_HEX),
    .TICK_CYCLES(TC), .DEBOUNCE_TICKS(DT), .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .key_i(key_i), .sw_i(sw_i),
    .key_o(key_o), .sw_o(sw_o), .key_press_o(key_press_o),
    .key_release_o(key_release_o), .key_pending_o(key_pending_o),
    .key_clr_i(key_clr_i), .hex_we_i(hex_we_i), .hex_value_i(hex_value_i),
    .hex_blank_i(hex_blank_i), .hex_o(hex_o)
  );

  always #5 clk = ~clk;

  // Reference model: active-low segment table written from the display charset.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state. A channel accepts a new level once DT ticks have fallen inside
  // one unbroken run of edges where its synced input disagrees with the accepted level.
  logic [NCH-1:0]       m_p1, m_p2;          // logical pin one and two edges back
  logic [NCH-1:0]       m_stable, m_stable_prev;
  int                   m_run [NCH];         // edge index where the current mismatch run began, -1 if none
  int                   m_k;                 // edges since reset release
  logic [W_KEY-1:0]     m_press, m_release, m_pending;
  logic [7*N_HEX-1:0]   m_hex;

  task automatic model_reset();
    m_p1 = '0; m_p2 = '0; m_stable = '0; m_stable_prev = '0;
    for (int c = 0; c < NCH; c++) m_run[c] = -1;
    m_k = 0; m_press = '0; m_release = '0; m_pending = '0;
    m_hex = {N_HEX{7'h7F}};
  endtask

  task automatic model_edge();
    logic [NCH-1:0]   pin;
    logic [W_KEY-1:0] np, nr;
    int               ticks;
    if (reset) return;
    pin = {sw_i, ~key_i};
    np  = m_stable[W_KEY-1:0] & ~m_stable_prev[W_KEY-1:0];
    nr  = ~m_stable[W_KEY-1:0] & m_stable_prev[W_KEY-1:0];
    m_pending = (m_pending & ~key_clr_i) | m_press;
    m_press = np;
    m_release = nr;
    m_stable_prev = m_stable;
    for (int c = 0; c < NCH; c++) begin
      if (m_p2[c] == m_stable[c]) begin
        m_run[c] = -1;
      end else begin
        if (m_run[c] < 0) m_run[c] = m_k;
        // ticks fall on edges k with k mod TC == TC-1; count them in [run start, now]
        ticks = (m_k + 1) / TC - m_run[c] / TC;
        if (ticks >= DT) begin
          m_stable[c] = m_p2[c];
          m_run[c] = -1;
        end
      end
    end
    m_p2 = m_p1;
    m_p1 = pin;
    if (hex_we_i) begin
      for (int d = 0; d < N_HEX; d++)
        m_hex[7*d +: 7] = hex_blank_i[d] ? 7'h7F : seg_tab[hex_value_i[4*d +: 4]];
    end
    m_k++;
  endtask

  // One clock edge; model advances with the inputs seen at the edge, outputs sampled 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    key_i = '1; sw_i = '0; reset = 1'b1;
    model_reset();
    repeat (3) cyc();
    n_chk++; if (hex_o !== {N_HEX{7'h7F}}) $display("FAIL reset_hex: got %h want %h", hex_o, {N_HEX{7'h7F}}); else n_pass++;
    n_chk++; if (key_o !== 4'h0) $display("FAIL reset_key: got %h want 0", key_o); else n_pass++;
    n_chk++; if (sw_o !== 18'h0) $display("FAIL reset_sw: got %h want 0", sw_o); else n_pass++;
    n_chk++; if (key_pending_o !== 4'h0) $display("FAIL reset_pending: got %h want 0", key_pending_o); else n_pass++;
    n_chk++; if ((key_press_o | key_release_o) !== 4'h0) $display("FAIL reset_events: got %h/%h want 0", key_press_o, key_release_o); else n_pass++;
    reset = 1'b0;
    repeat (16) cyc();
    n_chk++; if (key_o !== 4'h0) $display("FAIL idle_keys: got %h want 0", key_o); else n_pass++;
  endtask

  task automatic test_bouncing_key();
    int len [4] = '{5, 3, 6, 16};
    logic lvl [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    int bad = 0;
    for (int s = 0; s < 4; s++) begin
      key_i[1] = lvl[s];
      for (int n = 0; n < len[s]; n++) begin
        cyc();
        if (key_o[1] !== 1'b0 || key_press_o[1] !== 1'b0) bad++;
        n_chk++;
        if ({sw_o, key_o} !== m_stable || key_press_o !== m_press)
          $display("FAIL bounce_model: key %h press %h want key %h press %h", key_o, key_press_o, m_stable[W_KEY-1:0], m_press);
        else n_pass++;
      end
    end
    n_chk++; if (bad !== 0) $display("FAIL bounce_ignored: %0d cycles with key_o[1]/press[1] set, want 0", bad); else n_pass++;
  endtask

  task automatic test_clean_press();
    int lat = -1;
    int presses = 0;
    int releases = 0;
    key_i[1] = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (key_o[1] === 1'b1 && lat < 0) lat = n;
      if (key_press_o[1] === 1'b1) presses++;
      n_chk++;
      if (key_o !== m_stable[W_KEY-1:0] || key_press_o !== m_press || key_pending_o !== m_pending)
        $display("FAIL press_model: key %h press %h pend %h want %h %h %h", key_o, key_press_o, key_pending_o, m_stable[W_KEY-1:0], m_press, m_pending);
      else n_pass++;
    end
    n_chk++; if (lat < 2 + (DT-1)*TC || lat > 2 + DT*TC) $display("FAIL press_latency: got %0d want 10..14", lat); else n_pass++;
    n_chk++; if (presses !== 1) $display("FAIL press_pulses: got %0d want 1", presses); else n_pass++;
    n_chk++; if (key_pending_o[1] !== 1'b1) $display("FAIL press_pending: got %b want 1", key_pending_o[1]); else n_pass++;
    key_i[1] = 1'b1;
    presses = 0;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      if (key_release_o[1] === 1'b1) releases++;
      if (key_press_o[1] === 1'b1) presses++;
    end
    n_chk++; if (releases !== 1 || presses !== 0) $display("FAIL release_pulses: got rel %0d press %0d want 1 0", releases, presses); else n_pass++;
    n_chk++; if (key_o[1] !== 1'b0 || key_pending_o[1] !== 1'b1) $display("FAIL release_state: key %b pend %b want 0 1", key_o[1], key_pending_o[1]); else n_pass++;
  endtask

  task automatic test_hex_write();
    logic [7*N_HEX-1:0] first;
    hex_value_i = 32'h0123_ABCD; hex_blank_i = 8'h00; hex_we_i = 1'b1;
    cyc();
    hex_we_i = 1'b0;
    n_chk++; if (hex_o[6:0] !== 7'h21) $display("FAIL hex_digit0: got %h want 21", hex_o[6:0]); else n_pass++;
    n_chk++; if (hex_o[27:21] !== 7'h08) $display("FAIL hex_digit3: got %h want 08", hex_o[27:21]); else n_pass++;
    n_chk++; if (hex_o[55:49] !== 7'h40) $display("FAIL hex_digit7: got %h want 40", hex_o[55:49]); else n_pass++;
    n_chk++; if (hex_o !== m_hex) $display("FAIL hex_all: got %h want %h", hex_o, m_hex); else n_pass++;
    first = hex_o;
    hex_blank_i = 8'hF0; hex_we_i = 1'b1;
    cyc();
    hex_we_i = 1'b0;
    n_chk++; if (hex_o[55:28] !== {4{7'h7F}}) $display("FAIL hex_blank_hi: got %h want %h", hex_o[55:28], {4{7'h7F}}); else n_pass++;
    n_chk++; if (hex_o[27:0] !== first[27:0]) $display("FAIL hex_keep_lo: got %h want %h", hex_o[27:0], first[27:0]); else n_pass++;
    hex_value_i = $urandom; hex_blank_i = '0;
    repeat (3) cyc();
    n_chk++; if (hex_o !== m_hex) $display("FAIL hex_hold: got %h want %h", hex_o, m_hex); else n_pass++;
    for (int w = 0; w < 8; w++) begin
      hex_value_i = $urandom; hex_blank_i = 8'($urandom); hex_we_i = 1'b1;
      cyc();
      hex_we_i = 1'b0;
      n_chk++; if (hex_o !== m_hex) $display("FAIL hex_rand: got %h want %h", hex_o, m_hex); else n_pass++;
    end
  endtask

  task automatic test_clr_vs_set();
    bit seen = 0;
    key_i[2] = 1'b0;
    for (int n = 0; n < 30 && !seen; n++) begin
      cyc();
      if (key_press_o[2] === 1'b1) seen = 1;
    end
    n_chk++; if (!seen) $display("FAIL clr_press_seen: no press[2] within 30 cycles, want one"); else n_pass++;
    key_clr_i = 4'b0100;
    cyc();
    n_chk++; if (key_pending_o[2] !== 1'b1) $display("FAIL clr_set_wins: got %b want 1", key_pending_o[2]); else n_pass++;
    cyc();
    key_clr_i = '0;
    n_chk++; if (key_pending_o[2] !== 1'b0) $display("FAIL clr_alone: got %b want 0", key_pending_o[2]); else n_pass++;
    n_chk++; if (key_pending_o !== m_pending) $display("FAIL clr_model: got %h want %h", key_pending_o, m_pending); else n_pass++;
    key_i[2] = 1'b1;
    repeat (20) cyc();
  endtask

  task automatic test_reset_mid_debounce();
    int lat = -1;
    sw_i[17] = 1'b1;
    repeat (6) cyc();
    reset = 1'b1;
    model_reset();
    #1;
    n_chk++; if (sw_o[17] !== 1'b0) $display("FAIL rstmid_async: got %b want 0", sw_o[17]); else n_pass++;
    cyc();
    reset = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      cyc();
      if (sw_o[17] === 1'b1 && lat < 0) lat = n;
      n_chk++;
      if ({sw_o, key_o} !== m_stable) $display("FAIL rstmid_model: got %h want %h", {sw_o, key_o}, m_stable); else n_pass++;
    end
    n_chk++; if (lat < 2 + (DT-1)*TC || lat > 2 + DT*TC) $display("FAIL rstmid_latency: got %0d want 10..14", lat); else n_pass++;
    n_chk++; if (hex_o !== {N_HEX{7'h7F}}) $display("FAIL rstmid_hex: got %h want blank", hex_o); else n_pass++;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int b = 0; b < W_KEY; b++) if ($urandom_range(0, 19) == 0) key_i[b] = ~key_i[b];
      for (int b = 0; b < W_SW; b++) if ($urandom_range(0, 19) == 0) sw_i[b] = ~sw_i[b];
      key_clr_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      hex_we_i = ($urandom_range(0, 9) == 0);
      hex_value_i = $urandom;
      hex_blank_i = 8'($urandom);
      cyc();
      n_chk++;
      if ({sw_o, key_o} !== m_stable || key_press_o !== m_press || key_release_o !== m_release ||
          key_pending_o !== m_pending || hex_o !== m_hex)
        $display("FAIL rand_cycle%0d: deb %h p %h r %h pend %h hex %h want %h %h %h %h %h", n,
                 {sw_o, key_o}, key_press_o, key_release_o, key_pending_o, hex_o,
                 m_stable, m_press, m_release, m_pending, m_hex);
      else n_pass++;
    end
    key_clr_i = '0;
    hex_we_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bouncing_key();
    test_clean_press();
    test_hex_write();
    test_clr_vs_set();
    test_reset_mid_debounce();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
